// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, 8N1, LSB first, idle-high TXD.
// A one-byte holding register decouples core logic from the shifter; the
// host's active-low CTS# gates only the start of each frame.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1 framing).
//
// Handshake: a byte is taken on any rising edge where tx_data_ready=1 and
// tx_busy=0; tx_busy mirrors the registered hold_valid flag, so an offer made
// while tx_busy=1 is silently dropped and the edge that empties the holding
// register can never also fill it.
module uart_tx #(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_data_ready,
    input  logic       cts,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    hold;
    logic          hold_valid;
    logic [7:0]    shifter;
    logic [2:0]    bit_idx;
    logic          cts_meta;
    logic          cts_sync;
    logic          cts_ok;
    logic          start_frame;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    assign cts_ok  = ~cts_sync;
    assign tx_busy = hold_valid;

    // A new frame starts from IDLE, or straight out of the last stop-bit
    // cycle so back-to-back bytes leave no idle gap on the line.
    assign start_frame = hold_valid && cts_ok &&
                         ((state == IDLE) || ((state == STOP) && (cnt == CNT_LAST)));

    // Two-flop synchroniser for the asynchronous CTS# input; resets to
    // "not clear" so nothing is sent until the host is seen asserting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts;
            cts_sync <= cts_meta;
        end
    end

    // Holding register: filled by the handshake, emptied when a frame starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold       <= 8'h00;
            hold_valid <= 1'b0;
        end else if (start_frame) begin
            hold_valid <= 1'b0;
        end else if (tx_data_ready && !hold_valid) begin
            hold       <= tx_data;
            hold_valid <= 1'b1;
        end
    end

    // Frame FSM with baud counter; tx and tx_done are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
            shifter <= 8'h00;
            bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx  <= 1'b1;
                    cnt <= '0;
                    if (start_frame) begin
                        state   <= START;
                        tx      <= 1'b0;
                        shifter <= hold;
                        bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^hold;
`endif
                    end
                end
                START: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= DATA;
                        tx    <= shifter[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= parity_bit;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shifter <= shifter >> 1;
                            tx      <= shifter[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (start_frame) begin
                            state   <= START;
                            tx      <= 1'b0;
                            shifter <= hold;
                            bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^hold;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Raise tx_done so it is visible during the final stop cycle.
                        if (cnt == CNT_PRE) tx_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. A default-rate instance (104
// clocks per bit) carries most scenarios; a second instance at
// CLK_FREQ=400/BAUD=100 (4 clocks per bit) is checked cycle by cycle.
module tb_uart_tx;

    localparam int P  = 12000000 / 115200;
    localparam int SP = 400 / 100;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] tx_data;
    logic       tx_data_ready;
    logic       cts;
    logic       tx, tx_busy, tx_done;

    logic [7:0] s_data;
    logic       s_ready;
    logic       s_cts;
    logic       s_tx, s_busy, s_done;

    uart_tx dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
        .cts(cts), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.CLK_FREQ(400), .BAUD(100)) dut_s (
        .clk(clk), .reset(reset), .tx_data(s_data), .tx_data_ready(s_ready),
        .cts(s_cts), .tx(s_tx), .tx_busy(s_busy), .tx_done(s_done)
    );

    // scoreboard
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] b);
        tx_data       = b;
        tx_data_ready = 1'b1;
        exp_q.push_back(b);
        tick();
        tx_data_ready = 1'b0;
    endtask

    // Called one step after the edge that drove the start bit low. Samples
    // bit centres, rebuilds the byte, and ends in the last stop-bit cycle.
    task automatic watch_frame(input string tag, input int offer_c,
                               input logic [7:0] offer_b, input int cts_c);
        logic [7:0] rx;
        logic [7:0] exp_b;
        int done_n;
        int done_at;
        int k;
        rx      = 8'h00;
        done_n  = 0;
        done_at = -1;
        for (int c = 0; c < NB * P; c++) begin
            if (c % P == P / 2) begin
                k = c / P;
                if (k == 0) check({tag, ".start"}, tx, 1'b0);
                else if (k <= 8) rx[k-1] = tx;
`ifdef UART_TX_PARITY_EN
                else if (k == 9) check({tag, ".parity"}, tx, ^rx);
`endif
                else check({tag, ".stop"}, tx, 1'b1);
            end
            if (tx_done) begin
                done_n++;
                done_at = c;
            end
            if (c == offer_c) begin
                tx_data       = offer_b;
                tx_data_ready = 1'b1;
                exp_q.push_back(offer_b);
            end
            if (c == offer_c + 1) begin
                check({tag, ".busy_after_offer"}, tx_busy, 1'b1);
                tx_data = 8'hEE;
            end
            if (c == offer_c + 3) tx_data_ready = 1'b0;
            if (c == cts_c) cts = 1'b1;
            if (c < NB * P - 1) tick();
        end
        check({tag, ".done_count"}, done_n, 1);
        check({tag, ".done_cycle"}, done_at, NB * P - 1);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, ".byte"}, rx, exp_b);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;
        int dones;
        logic [10:0] sb;

        reset         = 1'b1;
        tx_data       = 8'h00;
        tx_data_ready = 1'b0;
        cts           = 1'b0;
        s_data        = 8'h00;
        s_ready       = 1'b0;
        s_cts         = 1'b0;
        repeat (3) tick();
        check("rst.tx", tx, 1'b1);
        check("rst.busy", tx_busy, 1'b0);
        check("rst.done", tx_done, 1'b0);
        check("rst.s_tx", s_tx, 1'b1);
        reset = 1'b0;
        repeat (3) tick();

        // single byte 0xA5
        offer(8'hA5);
        check("t1.busy_e0", tx_busy, 1'b1);
        check("t1.tx_e0", tx, 1'b1);
        tick();
        check("t1.tx_e1", tx, 1'b0);
        check("t1.busy_e1", tx_busy, 1'b0);
        watch_frame("t1", -10, 8'h00, -1);
        tick();
        check("t1.idle_tx", tx, 1'b1);
        check("t1.idle_done", tx_done, 1'b0);

        // back-to-back 0x55 then 0x0F; a third offer (0xEE) while full is dropped
        offer(8'h55);
        tick();
        check("t2.start", tx, 1'b0);
        watch_frame("t2a", 20, 8'h0F, -1);
        tick();
        check("t2.b2b_tx", tx, 1'b0);
        check("t2.b2b_busy", tx_busy, 1'b0);
        watch_frame("t2b", -10, 8'h00, -1);
        tick();
        check("t2.idle_tx", tx, 1'b1);

        // CTS# deasserted holds the byte; asserting it starts within 3 cycles
        cts = 1'b1;
        repeat (4) tick();
        offer(8'h3C);
        repeat (50) tick();
        check("t3.hold_tx", tx, 1'b1);
        check("t3.hold_busy", tx_busy, 1'b1);
        cts = 1'b0;
        n = 0;
        while (tx !== 1'b0 && n < 6) begin
            tick();
            n++;
        end
        check("t3.cts_latency_ok", (n >= 2 && n <= 3), 1'b1);
        check("t3.busy_cleared", tx_busy, 1'b0);
        watch_frame("t3", -10, 8'h00, 4 * P);
        tick();
        check("t3.idle_tx", tx, 1'b1);
        cts = 1'b0;
        repeat (3) tick();

        // reset during data bit 4 of 0xFF with 0x81 held
        offer(8'hFF);
        tick();
        check("t4.start", tx, 1'b0);
        repeat (20) tick();
        offer(8'h81);
        check("t4.held", tx_busy, 1'b1);
        repeat (5 * P + P / 2 - 21) tick();
        reset = 1'b1;
        tick();
        check("t4.rst_tx", tx, 1'b1);
        check("t4.rst_busy", tx_busy, 1'b0);
        check("t4.rst_done", tx_done, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        lows  = 0;
        dones = 0;
        for (int c = 0; c < 3 * P; c++) begin
            if (tx !== 1'b1) lows++;
            if (tx_done) dones++;
            tick();
        end
        check("t4.quiet_tx", lows, 0);
        check("t4.quiet_done", dones, 0);
        offer(8'h01);
        tick();
        check("t4.start2", tx, 1'b0);
        watch_frame("t4", -10, 8'h00, -1);
        tick();

`ifdef UART_TX_PARITY_EN
        // parity frames 0x07 (parity 1) and 0x03 (parity 0)
        offer(8'h07);
        tick();
        watch_frame("t6a", -10, 8'h00, -1);
        tick();
        offer(8'h03);
        tick();
        watch_frame("t6b", -10, 8'h00, -1);
        tick();
`endif

        // 4 clocks per bit: every cycle of the 0x3A frame checked
        sb = '1;
        sb[0] = 1'b0;
        for (int i = 0; i < 8; i++) sb[1 + i] = s_data[i] | 1'b0;
        s_data  = 8'h3A;
        for (int i = 0; i < 8; i++) sb[1 + i] = s_data[i];
`ifdef UART_TX_PARITY_EN
        sb[9] = ^s_data;
`endif
        sb[NB - 1] = 1'b1;
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        check("t5.busy", s_busy, 1'b1);
        tick();
        for (int c = 0; c < NB * SP; c++) begin
            check($sformatf("t5.tx_c%0d", c), s_tx, sb[c / SP]);
            check($sformatf("t5.done_c%0d", c), s_done, (c == NB * SP - 1));
            tick();
        end
        check("t5.idle_tx", s_tx, 1'b1);

        // report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
